prog_launcher: RTL and testbench

//  Host-side initiator for the processor's Start/Ack handshake. It runs NUM_PROGS

---
 rtl/prog_launcher_pkg.sv | 15 +
 rtl/sat_counter.sv | 29 ++
 rtl/prog_launcher.sv | 127 ++++++++++++
 tb/tb_prog_launcher.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_launcher_pkg.sv
// Shared types and constants for the program launcher.
package prog_launcher_pkg;

    typedef enum logic [2:0] {
        L_IDLE,
        L_START,
        L_RUN,
        L_REPORT,
        L_DONE
    } launch_state_t;

    // RUN cycles during which DutAck is ignored; it may still be high from the previous program.
    localparam int ACK_BLANK_CYC = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. Clear has priority. The counter stops at the limit and never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);

    logic [W-1:0] r_count;

    assign count    = r_count;
    assign at_limit = (r_count == limit);

    // Count enabled cycles until the limit is reached; clear overrides enable.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (en && !at_limit)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/prog_launcher.sv
// Host-side Start/Ack initiator. It launches NUM_PROGS programs back to back,
// times each one in RUN cycles, abandons a program at TIMEOUT, and strobes one
// result per program.
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter  int          NUM_PROGS = 3,
    parameter  int          START_CYC = 2,
    parameter  int          CYC_W     = 16,
    parameter  int unsigned TIMEOUT   = 32'hFFF0,
    localparam int          PI_W      = $clog2(NUM_PROGS + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             DutAck,
    output logic             DutStart,
    output logic [PI_W-1:0]  ProgIdx,
    output logic [CYC_W-1:0] CycleCount,
    output logic             ResultValid,
    output logic             TimedOut,
    output logic             AnyTimeout,
    output logic             Busy,
    output logic             Done
);

    localparam logic [CYC_W-1:0] TO_L    = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] START_L = CYC_W'(START_CYC - 1);
    localparam logic [CYC_W-1:0] BLANK_L = CYC_W'(ACK_BLANK_CYC);
    localparam logic [PI_W-1:0]  LAST_L  = PI_W'(NUM_PROGS - 1);

    launch_state_t    r_state, w_next;
    logic [CYC_W-1:0] w_hold_cnt, w_run_cnt;
    logic             w_hold_done, w_run_at_to;
    logic             w_ack_ok, w_timeout, w_launch;
    logic             r_DutStart, r_TimedOut, r_AnyTimeout;
    logic [PI_W-1:0]  r_ProgIdx;
    logic [CYC_W-1:0] r_CycleCount;

    // START needs only the limit flag. The hold count value has no other consumer.
    logic w_unused_hold;
    assign w_unused_hold = ^w_hold_cnt;

    // Counts START cycles. The hold counter is zero on the first START cycle.
    sat_counter #(.W(CYC_W)) u_hold (
        .Clk      (Clk),
        .Reset    (Reset),
        .clr      (r_state != L_START),
        .en       (r_state == L_START),
        .limit    (START_L),
        .count    (w_hold_cnt),
        .at_limit (w_hold_done)
    );

    // Counts RUN cycles. The counter steps on entry into RUN, so it reads 1 on the first RUN cycle.
    sat_counter #(.W(CYC_W)) u_run (
        .Clk      (Clk),
        .Reset    (Reset),
        .clr      (w_next != L_RUN),
        .en       (w_next == L_RUN),
        .limit    (TO_L),
        .count    (w_run_cnt),
        .at_limit (w_run_at_to)
    );

    // Next-state logic. When an ack and a timeout occur in the same cycle, the ack wins.
    always_comb begin
        w_next    = r_state;
        w_ack_ok  = 1'b0;
        w_timeout = 1'b0;
        w_launch  = 1'b0;
        unique case (r_state)
            L_IDLE, L_DONE: begin
                w_launch = Go;
                if (Go) w_next = L_START;
            end
            L_START: if (w_hold_done) w_next = L_RUN;
            L_RUN: begin
                w_ack_ok  = DutAck && (w_run_cnt > BLANK_L);
                w_timeout = !w_ack_ok && w_run_at_to;
                if (w_ack_ok || w_timeout) w_next = L_REPORT;
            end
            L_REPORT: w_next = (r_ProgIdx == LAST_L) ? L_DONE : L_START;
            default:  w_next = L_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= L_IDLE;
        else        r_state <= w_next;
    end

    // Registered start pulse, program index, latched result and sticky timeout flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_DutStart   <= 1'b0;
            r_ProgIdx    <= '0;
            r_CycleCount <= '0;
            r_TimedOut   <= 1'b0;
            r_AnyTimeout <= 1'b0;
        end else begin
            r_DutStart <= (w_next == L_START);
            if (w_launch) begin
                r_ProgIdx    <= '0;
                r_AnyTimeout <= 1'b0;
            end else if (r_state == L_REPORT && w_next == L_START) begin
                r_ProgIdx <= r_ProgIdx + 1'b1;
            end
            if (w_next == L_REPORT) begin
                r_CycleCount <= w_run_cnt;
                r_TimedOut   <= w_timeout;
                if (w_timeout) r_AnyTimeout <= 1'b1;
            end
        end
    end

    assign DutStart    = r_DutStart;
    assign ProgIdx     = r_ProgIdx;
    assign CycleCount  = r_CycleCount;
    assign TimedOut    = r_TimedOut;
    assign AnyTimeout  = r_AnyTimeout;
    assign ResultValid = (r_state == L_REPORT);
    assign Busy        = (r_state != L_IDLE) && (r_state != L_DONE);
    assign Done        = (r_state == L_DONE);

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher.
// Each program is described by its ack delay d: the bench raises DutAck on RUN
// cycle d (d == 0 means DutAck is already high before the launch) and holds it.
// The expected result follows from the launcher's rules:
//   count = min(max(d, 2), TIMEOUT), timedout = (d > TIMEOUT).
module tb_prog_launcher;

    localparam int NP = 3;
    localparam int SC = 2;
    localparam int CW = 16;
    localparam int TO = 20;
    localparam int PW = $clog2(NP + 1);
    localparam int NRUNS = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Go = 1'b0;
    logic          DutAck = 1'b0;
    logic          DutStart, ResultValid, TimedOut, AnyTimeout, Busy, Done;
    logic [PW-1:0] ProgIdx;
    logic [CW-1:0] CycleCount;

    int errors = 0;
    int checks = 0;

    prog_launcher #(
        .NUM_PROGS (NP),
        .START_CYC (SC),
        .CYC_W     (CW),
        .TIMEOUT   (TO)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Go          (Go),
        .DutAck      (DutAck),
        .DutStart    (DutStart),
        .ProgIdx     (ProgIdx),
        .CycleCount  (CycleCount),
        .ResultValid (ResultValid),
        .TimedOut    (TimedOut),
        .AnyTimeout  (AnyTimeout),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    // One program: the ack delay and the expected report.
    typedef struct packed {
        int d;
        int cnt;
        bit to;
        bit any;
    } prog_vec_t;

    prog_vec_t tbl [NRUNS][NP];

    function automatic prog_vec_t mk(input int d, input int cnt, input bit to, input bit any);
        prog_vec_t v;
        v.d = d; v.cnt = cnt; v.to = to; v.any = any;
        return v;
    endfunction

    // Reference model derived from the launcher's rules.
    function automatic prog_vec_t model(input int d, input bit any_in);
        prog_vec_t v;
        v.d   = d;
        v.to  = (d > TO);
        v.cnt = v.to ? TO : ((d < 2) ? 2 : d);
        v.any = any_in | v.to;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one program starting before or at its START phase. Returns at the
    // negedge after its report.
    task automatic run_one(input int d, input int idx, input int ecnt, input bit eto, input bit eany);
        int n, k;
        bit got;
        DutAck = (d == 0);
        n = 0;
        while (!DutStart && n < 8) begin @(negedge Clk); n++; end
        chk("start_rise", DutStart, 1);
        if (!DutStart) return;
        chk("busy_start", Busy, 1);
        n = 0;
        while (DutStart && n < 8) begin @(negedge Clk); n++; end
        chk("start_width", n, SC);
        chk("prog_idx_run", ProgIdx, idx);
        if (idx == 0) chk("any_clear", AnyTimeout, 0);
        got = 1'b0;
        for (k = 1; k <= TO + 4; k++) begin
            DutAck = (k >= d);
            Go = 1'($urandom_range(0, 1));   // Go is ignored while Busy
            @(negedge Clk);
            if (ResultValid) begin got = 1'b1; break; end
        end
        Go = 1'b0;
        chk("rv_seen", got, 1);
        if (!got) return;
        chk("rv_latency", k, ecnt);
        chk("cycle_count", CycleCount, ecnt);
        chk("timed_out", TimedOut, eto);
        chk("any_timeout", AnyTimeout, eany);
        chk("prog_idx_rv", ProgIdx, idx);
        @(negedge Clk);
        chk("rv_single", ResultValid, 0);
    endtask

    task automatic do_run(input int r);
        @(negedge Clk);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        chk("go_latency", DutStart, 1);
        for (int i = 0; i < NP; i++)
            run_one(tbl[r][i].d, i, tbl[r][i].cnt, tbl[r][i].to, tbl[r][i].any);
        chk("done", Done, 1);
        chk("busy_done", Busy, 0);
        chk("idx_done", ProgIdx, NP - 1);
        repeat (3) @(negedge Clk);
        chk("done_hold", Done, 1);
        chk("count_hold", CycleCount, tbl[r][NP-1].cnt);
        chk("any_hold", AnyTimeout, tbl[r][NP-1].any);
        chk("idx_hold", ProgIdx, NP - 1);
        chk("rv_done", ResultValid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit any;
        // Directed runs: nominal, stale ack and blanking, timeout, boundary at TIMEOUT.
        tbl[0][0] = mk(10, 10, 0, 0);   tbl[0][1] = mk(10, 10, 0, 0); tbl[0][2] = mk(10, 10, 0, 0);
        tbl[1][0] = mk(0, 2, 0, 0);     tbl[1][1] = mk(1, 2, 0, 0);   tbl[1][2] = mk(5, 5, 0, 0);
        tbl[2][0] = mk(10, 10, 0, 0);   tbl[2][1] = mk(1000, 20, 1, 1); tbl[2][2] = mk(3, 3, 0, 1);
        tbl[3][0] = mk(20, 20, 0, 0);   tbl[3][1] = mk(21, 20, 1, 1); tbl[3][2] = mk(19, 19, 0, 1);
        for (int r = 4; r < NRUNS; r++) begin
            any = 1'b0;
            for (int i = 0; i < NP; i++) begin
                tbl[r][i] = model(int'($urandom_range(0, TO + 5)), any);
                any = tbl[r][i].any;
            end
        end

        // Reset state
        #12;
        chk("rst_dutstart", DutStart, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_rv", ResultValid, 0);
        chk("rst_idx", ProgIdx, 0);
        chk("rst_count", CycleCount, 0);
        chk("rst_to", TimedOut, 0);
        chk("rst_any", AnyTimeout, 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("idle_busy", Busy, 0);
        chk("idle_start", DutStart, 0);

        for (int r = 0; r < NRUNS; r++) do_run(r);

        // Reset mid-RUN of program 1
        @(negedge Clk);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        run_one(4, 0, 4, 0, 0);
        DutAck = 1'b0;
        n = 0;
        while (DutStart && n < 8) begin @(negedge Clk); n++; end
        repeat (2) @(negedge Clk);
        chk("pre_rst_busy", Busy, 1);
        #2 Reset = 1'b0;
        #1;
        chk("midrun_dutstart", DutStart, 0);
        chk("midrun_busy", Busy, 0);
        chk("midrun_idx", ProgIdx, 0);
        chk("midrun_count", CycleCount, 0);
        chk("midrun_rv", ResultValid, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Reset while DutStart is high: DutStart drops without a clock edge
        @(negedge Clk);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        chk("start_hi", DutStart, 1);
        #2 Reset = 1'b0;
        #1;
        chk("start_async_drop", DutStart, 0);
        chk("start_rst_busy", Busy, 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("post_rst_idle", Busy, 0);

        // Recovery after reset
        do_run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
